// File: rtl/exe_div_seq_pkg.sv
// rtl/exe_div_seq_pkg.sv - shared state encoding, size codes and sign helper for exe_div_seq
package exe_div_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_ITER = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_8  = 2'd0;
  localparam logic [1:0] SIZE_16 = 2'd1;
  localparam logic [1:0] SIZE_32 = 2'd2;

  localparam logic [5:0] N_8  = 6'd8;
  localparam logic [5:0] N_16 = 6'd16;
  localparam logic [5:0] N_32 = 6'd32;

  // Size code 3 is treated as 32-bit.
  function automatic logic [5:0] size_to_n(input logic [1:0] size);
    logic [5:0] n;
    case (size)
      SIZE_8:  n = N_8;
      SIZE_16: n = N_16;
      default: n = N_32;
    endcase
    return n;
  endfunction

  // Two's-complement negate when neg is set, truncated to the low 'bits' bits (bits may be 64).
  function automatic logic [63:0] cond_neg(input logic [63:0] v, input logic neg,
                                           input logic [6:0] bits);
    logic [63:0] mask;
    mask = (64'd1 << bits) - 64'd1;
    return (neg ? (~v + 64'd1) : v) & mask;
  endfunction

endpackage

// File: rtl/exe_div_seq_if.sv
// rtl/exe_div_seq_if.sv - divider request/result bundle
interface exe_div_seq_if;
  import exe_div_seq_pkg::*;

  logic        exe_reset;
  logic        div_start;
  logic        div_signed;
  logic [1:0]  div_size;
  logic [63:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_busy;
  logic        div_done;
  logic        exe_div_exception;
  logic [31:0] div_result_quotient;
  logic [31:0] div_result_remainder;

  modport master (
    output exe_reset, div_start, div_signed, div_size, div_dividend, div_divisor,
    input  div_busy, div_done, exe_div_exception, div_result_quotient, div_result_remainder
  );

  modport slave (
    input  exe_reset, div_start, div_signed, div_size, div_dividend, div_divisor,
    output div_busy, div_done, exe_div_exception, div_result_quotient, div_result_remainder
  );

endinterface

// File: rtl/exe_div_seq.sv
// rtl/exe_div_seq.sv - sequential restoring DIV/IDIV unit for 8/16/32-bit operands
module exe_div_seq
  import exe_div_seq_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  exe_div_seq_if.slave bus
);

  state_t      r_state, w_next;
  logic        r_signed;
  logic [5:0]  r_n;
  logic [63:0] r_dvd;
  logic [31:0] r_dvs;
  logic        r_q_neg, r_r_neg, r_exc_early;
  logic [31:0] r_rem, r_low, r_quo;
  logic [5:0]  r_cnt;
  logic        r_done, r_exc;
  logic [31:0] r_q_out, r_r_out;

  logic [6:0]  w_two_n;
  logic [5:0]  w_dvd_msb;
  logic [4:0]  w_dvs_msb;
  logic        w_dvd_sign, w_dvs_sign;
  logic [63:0] w_dvd_mag, w_dvs_mag64, w_hi;
  logic [31:0] w_dvs_mag, w_lo;
  logic        w_prep_exc;

  assign w_two_n    = {r_n, 1'b0};
  assign w_dvd_msb  = w_two_n[5:0] - 6'd1;
  assign w_dvs_msb  = r_n[4:0] - 5'd1;
  assign w_dvd_sign = r_signed & r_dvd[w_dvd_msb];
  assign w_dvs_sign = r_signed & r_dvs[w_dvs_msb];
  assign w_dvd_mag  = cond_neg(r_dvd, w_dvd_sign, w_two_n);
  assign w_dvs_mag64 = cond_neg({32'd0, r_dvs}, w_dvs_sign, {1'b0, r_n});
  assign w_dvs_mag  = w_dvs_mag64[31:0];
  assign w_hi       = w_dvd_mag >> r_n;
  // Low N dividend bits left-aligned so ITER always shifts out of bit 31.
  assign w_lo       = w_dvd_mag[31:0] << (6'd32 - r_n);
  assign w_prep_exc = (w_dvs_mag == 32'd0) || (w_hi >= {32'd0, w_dvs_mag});

  logic [31:0] w_it_rem, w_it_low, w_it_quo;
  logic [32:0] w_t;

  // r_dvs holds the divisor magnitude once PREP has run.
  always_comb begin
    w_it_rem = r_rem;
    w_it_low = r_low;
    w_it_quo = r_quo;
    w_t      = 33'd0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      w_t      = {w_it_rem, w_it_low[31]};
      w_it_low = w_it_low << 1;
      if (w_t >= {1'b0, r_dvs}) begin
        w_t      = w_t - {1'b0, r_dvs};
        w_it_quo = {w_it_quo[30:0], 1'b1};
      end else begin
        w_it_quo = {w_it_quo[30:0], 1'b0};
      end
      w_it_rem = w_t[31:0];
    end
  end

  logic [63:0] w_q_fix64, w_r_fix64;
  logic [32:0] w_lim;
  logic        w_fix_exc;

  assign w_q_fix64 = cond_neg({32'd0, r_quo}, r_q_neg, {1'b0, r_n});
  assign w_r_fix64 = cond_neg({32'd0, r_rem}, r_r_neg, {1'b0, r_n});
  assign w_lim     = 33'd1 << (r_n - 6'd1);
  assign w_fix_exc = r_signed && (r_q_neg ? ({1'b0, r_quo} > w_lim)
                                          : ({1'b0, r_quo} >= w_lim));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.div_start) w_next = S_PREP;
      S_PREP:  w_next = w_prep_exc ? S_FIX : S_ITER;
      S_ITER:  if (r_cnt == 6'd1) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (bus.exe_reset) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_signed    <= 1'b0;
      r_n         <= 6'd0;
      r_dvd       <= 64'd0;
      r_dvs       <= 32'd0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_exc_early <= 1'b0;
      r_rem       <= 32'd0;
      r_low       <= 32'd0;
      r_quo       <= 32'd0;
      r_cnt       <= 6'd0;
      r_done      <= 1'b0;
      r_exc       <= 1'b0;
      r_q_out     <= 32'd0;
      r_r_out     <= 32'd0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      if (!bus.exe_reset) begin
        case (r_state)
          S_IDLE: if (bus.div_start) begin
            r_signed <= bus.div_signed;
            r_n      <= size_to_n(bus.div_size);
            r_dvd    <= bus.div_dividend;
            r_dvs    <= bus.div_divisor;
          end
          S_PREP: begin
            r_dvs       <= w_dvs_mag;
            r_q_neg     <= w_dvd_sign ^ w_dvs_sign;
            r_r_neg     <= w_dvd_sign;
            r_exc_early <= w_prep_exc;
            r_rem       <= w_hi[31:0];
            r_low       <= w_lo;
            r_quo       <= 32'd0;
            r_cnt       <= (STEPS_PER_CYCLE == 2) ? {1'b0, r_n[5:1]} : r_n;
          end
          S_ITER: begin
            r_rem <= w_it_rem;
            r_low <= w_it_low;
            r_quo <= w_it_quo;
            r_cnt <= r_cnt - 6'd1;
          end
          S_FIX: begin
            r_done <= 1'b1;
            if (r_exc_early) begin
              r_q_out <= 32'd0;
              r_r_out <= 32'd0;
              r_exc   <= 1'b1;
            end else begin
              r_q_out <= w_q_fix64[31:0];
              r_r_out <= w_r_fix64[31:0];
              r_exc   <= w_fix_exc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.div_busy             = (r_state != S_IDLE) || r_done;
  assign bus.div_done             = r_done;
  assign bus.exe_div_exception    = r_exc;
  assign bus.div_result_quotient  = r_q_out;
  assign bus.div_result_remainder = r_r_out;

endmodule

// File: tb/tb_exe_div_seq.sv
// tb/tb_exe_div_seq.sv - directed bench for exe_div_seq at one and two quotient bits per cycle
module tb_exe_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        t_exe_reset = 1'b0;
  logic        t_start = 1'b0;
  logic        t_signed = 1'b0;
  logic [1:0]  t_size = 2'd0;
  logic [63:0] t_dvd = 64'd0;
  logic [31:0] t_dvs = 32'd0;

  int n_chk = 0;
  int n_err = 0;

  exe_div_seq_if if1();
  exe_div_seq_if if2();

  assign if1.exe_reset = t_exe_reset;
  assign if1.div_start = t_start;
  assign if1.div_signed = t_signed;
  assign if1.div_size = t_size;
  assign if1.div_dividend = t_dvd;
  assign if1.div_divisor = t_dvs;
  assign if2.exe_reset = t_exe_reset;
  assign if2.div_start = t_start;
  assign if2.div_signed = t_signed;
  assign if2.div_size = t_size;
  assign if2.div_dividend = t_dvd;
  assign if2.div_divisor = t_dvs;

  exe_div_seq #(.STEPS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  exe_div_seq #(.STEPS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; the start edge ends cycle 0.
  task automatic run(input string tag, input logic sg, input logic [1:0] sz,
                     input logic [63:0] dvd, input logic [31:0] dvs, input int poke,
                     input int e_c1, input int e_c2, input logic [31:0] eq,
                     input logic [31:0] er, input logic ee, input logic chk_qr);
    int c1, c2;
    logic b1, e1, e2;
    logic [31:0] q1, r1, q2, r2;
    c1 = -1; c2 = -1; b1 = 1'b0; e1 = 1'b0; e2 = 1'b0;
    q1 = '0; r1 = '0; q2 = '0; r2 = '0;
    t_signed = sg; t_size = sz; t_dvd = dvd; t_dvs = dvs; t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    for (int cyc = 1; cyc <= 60 && (c1 < 0 || c2 < 0); cyc++) begin
      if (if1.div_done && c1 < 0) begin
        c1 = cyc; b1 = if1.div_busy; e1 = if1.exe_div_exception;
        q1 = if1.div_result_quotient; r1 = if1.div_result_remainder;
      end
      if (if2.div_done && c2 < 0) begin
        c2 = cyc; e2 = if2.exe_div_exception;
        q2 = if2.div_result_quotient; r2 = if2.div_result_remainder;
      end
      if (c1 < 0 || c2 < 0) begin
        if (cyc == poke) begin
          t_signed = 1'b0; t_size = 2'd0; t_dvd = 64'd9; t_dvs = 32'd3; t_start = 1'b1;
        end
        @(posedge clk); #1;
        t_start = 1'b0;
      end
    end
    chk({tag, " done_cycle_s1"}, 64'(c1), 64'(e_c1));
    chk({tag, " done_cycle_s2"}, 64'(c2), 64'(e_c2));
    chk({tag, " busy_at_done"}, {63'd0, b1}, 64'd1);
    chk({tag, " exc_s1"}, {63'd0, e1}, {63'd0, ee});
    chk({tag, " exc_s2"}, {63'd0, e2}, {63'd0, ee});
    if (chk_qr) begin
      chk({tag, " quot_s1"}, {32'd0, q1}, {32'd0, eq});
      chk({tag, " rem_s1"}, {32'd0, r1}, {32'd0, er});
      chk({tag, " quot_s2"}, {32'd0, q2}, {32'd0, eq});
      chk({tag, " rem_s2"}, {32'd0, r2}, {32'd0, er});
    end
    @(posedge clk); #1;
    chk({tag, " busy_after"}, {63'd0, if1.div_busy}, 64'd0);
    chk({tag, " done_after"}, {63'd0, if1.div_done}, 64'd0);
  endtask

  initial begin
    int seen;
    @(posedge clk); #1;
    chk("rst busy", {63'd0, if1.div_busy}, 64'd0);
    chk("rst done", {63'd0, if1.div_done}, 64'd0);
    chk("rst exc", {63'd0, if1.exe_div_exception}, 64'd0);
    chk("rst quot", {32'd0, if1.div_result_quotient}, 64'd0);
    chk("rst rem", {32'd0, if1.div_result_remainder}, 64'd0);
    chk("rst busy_s2", {63'd0, if2.div_busy}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run("u32_100_7", 1'b0, 2'd2, 64'd100, 32'd7, 0, 35, 19, 32'd14, 32'd2, 1'b0, 1'b1);
    run("s8_m100_7", 1'b1, 2'd0, 64'hDEAD_0000_0000_FF9C, 32'hABCD_EF07, 0,
        11, 7, 32'h0000_00F2, 32'h0000_00FE, 1'b0, 1'b1);
    run("u16_div0", 1'b0, 2'd1, 64'h1234, 32'h0, 0, 3, 3, 32'd0, 32'd0, 1'b1, 1'b1);
    run("u16_ovf", 1'b0, 2'd1, 64'h0001_0000, 32'd1, 0, 3, 3, 32'd0, 32'd0, 1'b1, 1'b1);
    run("s8_m128_m1", 1'b1, 2'd0, 64'hFF80, 32'hFF, 0, 11, 7, 32'd0, 32'd0, 1'b1, 1'b0);
    run("s8_m128_1", 1'b1, 2'd0, 64'hFF80, 32'h01, 0, 11, 7, 32'h80, 32'd0, 1'b0, 1'b1);
    run("s16_7_m2", 1'b1, 2'd1, 64'd7, 32'hFFFE, 0, 19, 11, 32'hFFFD, 32'd1, 1'b0, 1'b1);
    run("u32_max", 1'b0, 2'd2, 64'hFFFF_FFFE_0000_0000, 32'hFFFF_FFFF, 0,
        35, 19, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 1'b1);
    run("u8_busy_start", 1'b0, 2'd0, 64'd200, 32'd10, 4, 11, 7, 32'd20, 32'd0, 1'b0, 1'b1);

    // Flush and start in the same cycle: the start must be dropped.
    t_signed = 1'b0; t_size = 2'd0; t_dvd = 64'd50; t_dvs = 32'd5;
    t_start = 1'b1; t_exe_reset = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0; t_exe_reset = 1'b0;
    chk("flush_start busy_s1", {63'd0, if1.div_busy}, 64'd0);
    chk("flush_start busy_s2", {63'd0, if2.div_busy}, 64'd0);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      if (if1.div_done || if2.div_done) seen++;
      @(posedge clk); #1;
    end
    chk("flush_start no_done", 64'(seen), 64'd0);
    chk("flush_start quot_held", {32'd0, if1.div_result_quotient}, 64'd20);

    // Flush in ITER cycle 5 (cycle 6), then restart at once.
    t_signed = 1'b0; t_size = 2'd1; t_dvd = 64'h1234; t_dvs = 32'h10; t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    t_exe_reset = 1'b1;
    @(posedge clk); #1;
    t_exe_reset = 1'b0;
    chk("abort busy_s1", {63'd0, if1.div_busy}, 64'd0);
    chk("abort busy_s2", {63'd0, if2.div_busy}, 64'd0);
    chk("abort done_s1", {63'd0, if1.div_done}, 64'd0);
    chk("abort quot_held", {32'd0, if1.div_result_quotient}, 64'd20);
    chk("abort rem_held", {32'd0, if1.div_result_remainder}, 64'd0);
    run("u16_restart", 1'b0, 2'd1, 64'h1234, 32'h10, 0, 19, 11, 32'h123, 32'd4, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/exe_div_seq.md
EXE_DIV_SEQ -- requirements
Module: exe_div_seq

Interface
REQ-001 Parameter: STEPS_PER_CYCLE, default 1, quotient bits resolved per ITER cycle; legal values 1 and 2.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 exe_reset  in  1  pipeline flush; synchronous abort of any division.
REQ-005 div_start  in  1  single-cycle start request.
REQ-006 div_signed  in  1  1=IDIV, 0=DIV; sampled with div_start.
REQ-007 div_size  in  2  0=8-bit, 1=16-bit, 2=32-bit (N=8/16/32); 3 is illegal, behaves as 2.
REQ-008 div_dividend  in  64  2N-bit dividend in bits [2N-1:0] (AX, DX:AX, EDX:EAX); upper bits ignored.
REQ-009 div_divisor  in  32  N-bit divisor in bits [N-1:0]; upper bits ignored.
REQ-010 div_busy  out  1  division in progress.
REQ-011 div_done  out  1  one-cycle completion pulse.
REQ-012 exe_div_exception  out  1  #DE condition, valid from div_done until the next accepted start.
REQ-013 div_result_quotient  out  32  quotient in [N-1:0], upper bits zero.
REQ-014 div_result_remainder  out  32  remainder in [N-1:0], upper bits zero.

Function
REQ-015 States: IDLE, PREP, ITER, FIX.
- IDLE->PREP on div_start.
- PREP->FIX on zero divisor or unsigned overflow; otherwise PREP->ITER.
- ITER->FIX after N/STEPS_PER_CYCLE cycles.
- FIX->IDLE unconditionally.
REQ-016 div_start is accepted only in IDLE; in any other state it is ignored with no side effect.
REQ-017 PREP latches operand magnitudes (two's-complement absolute value when div_signed), the dividend sign and the quotient sign (dividend sign XOR divisor sign).
REQ-018 PREP flags an exception when the divisor is zero, or when the high N bits of the dividend magnitude are >= the divisor magnitude.
REQ-019 ITER performs restoring shift-subtract on a (2N+1)-bit partial remainder, producing STEPS_PER_CYCLE quotient bits MSB-first per cycle.
REQ-020 FIX applies the signs: quotient negated if its sign is negative; remainder takes the dividend sign; both truncated to N bits.
REQ-021 FIX signed-range check:
- negative quotient: exception if magnitude > 2^(N-1);
- non-negative quotient: exception if magnitude > 2^(N-1)-1.
REQ-022 div_busy is high from the cycle after the accepted start through the div_done cycle, inclusive.
REQ-023 div_done is high in the cycle after FIX; quotient, remainder and exception update in that same cycle and hold until the next accepted start.
REQ-024 Latency from start cycle 0, STEPS_PER_CYCLE=1: div_done at cycle N+3 (8-bit: 11, 16-bit: 19, 32-bit: 35).
REQ-025 Early exception from PREP: div_done at cycle 3; quotient and remainder outputs are then zero.
REQ-026 With STEPS_PER_CYCLE=2, the ITER count halves; all other timing is unchanged.
REQ-027 exe_reset in any state: IDLE in the next cycle, div_busy low, no div_done pulse, and outputs keep their prior values.
REQ-028 exe_reset and div_start in the same cycle: exe_reset wins and the start is dropped.

Reset
REQ-029 rst forces IDLE, div_busy=0, div_done=0, exe_div_exception=0, quotient=0, remainder=0, and all internal registers to 0.
REQ-030 rst has priority over exe_reset and div_start.

Structure
REQ-031 The state encoding and the size-code constants (8/16/32) are defined in the shared defines package, not locally.
REQ-032 The block is a single module with no sub-modules; the negate/abs helper is shared between PREP and FIX.

Verification
REQ-033 32-bit unsigned, dividend 100, divisor 7 -> quotient 14, remainder 2, exception 0, div_done at cycle 35.
REQ-034 8-bit signed, dividend 0xFF9C (-100), divisor 0x07 -> quotient 0xF2, remainder 0xFE, exception 0, div_done at cycle 11.
REQ-035 16-bit unsigned, divisor 0 -> exception 1, div_done at cycle 3.
REQ-036 16-bit unsigned, dividend 0x00010000, divisor 1 -> exception 1 via the PREP check.
REQ-037 8-bit signed: 0xFF80 / 0xFF -> exception 1; 0xFF80 / 0x01 -> quotient 0x80, exception 0.
REQ-038 exe_reset at ITER cycle 5:
- div_busy low next cycle and no div_done pulse;
- a new start accepted the following cycle completes correctly.
